// File: rtl/ch_digital_ctrl_gen.sv
// ch_digital_ctrl_gen: trigger-driven ping-pong SCA bank sequencer; timestamps enabled by TRIG_TIMESTAMP_EN
module ch_digital_ctrl_gen #(
  parameter int NBANK = 4,
  parameter int DELAY_W = 5,
  parameter int ARM_CYCLES = 32,
  parameter int HOLD_W = 4,
  parameter int CNT_W = 10,
  localparam int MODE_W = $clog2(NBANK) + 1,
  localparam int TC_W = $clog2(NBANK + 1)
) (
  input  logic              FCLK,
  input  logic              RST,
  input  logic              INST_START,
  input  logic              INST_STOP,
  input  logic              INST_READOUT,
  input  logic              DISCRIMINATOR_OUTPUT,
  input  logic              DISCRIMINATOR_POLARITY,
  input  logic [MODE_W-1:0] MODE,
  input  logic [DELAY_W-1:0] TRIG_DELAY,
  input  logic [HOLD_W-1:0] HOLDOFF,
  input  logic [TC_W-1:0]   EVT_SEL,
  output logic [NBANK-1:0]  TRIGGER,
  output logic [NBANK-1:0]  TRIGGERC,
  output logic              TRIGGERE,
  output logic              STOP_REQUEST,
  output logic [TC_W-1:0]   TRIG_CNT,
  output logic [TC_W-1:0]   CUR_GRP,
  output logic [CNT_W-1:0]  EVT_TS
);
  localparam int LOG_N = $clog2(NBANK);
  localparam int DLEN = 2 ** DELAY_W - 1;
  localparam int BW = $clog2(ARM_CYCLES + 1);
  typedef enum logic [2:0] {INIT, SAMPLING, TAIL, STOPPED, READOUT} state_t;
  state_t state_q, state_d;
  logic s1_q, s2_q, lvl_q, lvl, trig, sreq_q, sreq_d, trge_q, trge_d;
  logic [DLEN-1:0] dl_q;
  logic [DLEN:0] ch;
  logic [MODE_W-1:0] gs_q, gs_d;
  logic [BW-1:0] blank_q, blank_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [TC_W-1:0] cnt_q, cnt_d, grp_q, grp_d, ngrp;
  logic [NBANK-1:0] trg_q, trg_d, trgc_q, trgc_d;
  // tap 0 is the synchroniser output, tap n is n cycles further down the line
  assign ch = {dl_q, s2_q};
  assign lvl = ch[TRIG_DELAY] ^ DISCRIMINATOR_POLARITY;
  assign ngrp = TC_W'(NBANK >> gs_q);
  assign trig = state_q == SAMPLING && blank_q == '0 && hold_q == '0 && lvl && !lvl_q;
  always_comb begin
    state_d = state_q;
    gs_d = gs_q;
    cnt_d = cnt_q;
    grp_d = grp_q;
    sreq_d = sreq_q;
    blank_d = blank_q != '0 ? blank_q - BW'(1) : blank_q;
    hold_d = hold_q != '0 ? hold_q - HOLD_W'(1) : hold_q;
    if (INST_START) begin
      state_d = SAMPLING;
      gs_d = MODE > MODE_W'(LOG_N) ? MODE_W'(LOG_N) : MODE;
      cnt_d = '0;
      grp_d = '0;
      sreq_d = 1'b0;
      blank_d = BW'(ARM_CYCLES);
    end else if (INST_STOP) state_d = STOPPED;
    else if (INST_READOUT) state_d = READOUT;
    else if (trig) begin
      cnt_d = cnt_q + TC_W'(1);
      sreq_d = 1'b1;
      hold_d = HOLDOFF;
      state_d = grp_q == ngrp - TC_W'(1) ? TAIL : SAMPLING;
      grp_d = grp_q == ngrp - TC_W'(1) ? grp_q : grp_q + TC_W'(1);
    end
    for (int b = 0; b < NBANK; b++) begin
      trg_d[b] = state_d == SAMPLING ? TC_W'(b >> gs_d) != grp_d : 1'b1;
      trgc_d[b] = state_d == SAMPLING ? TC_W'(b >> gs_d) < grp_d : 1'b1;
    end
    trge_d = !(state_d == SAMPLING || state_d == TAIL);
  end
  always_ff @(posedge FCLK) begin
    if (RST) begin
      state_q <= INIT;
      {s1_q, s2_q, lvl_q, sreq_q} <= '0;
      dl_q <= '0;
      gs_q <= '0;
      blank_q <= '0;
      hold_q <= '0;
      cnt_q <= '0;
      grp_q <= '0;
      trg_q <= '1;
      trgc_q <= '1;
      trge_q <= 1'b1;
    end else begin
      state_q <= state_d;
      s1_q <= DISCRIMINATOR_OUTPUT;
      s2_q <= s1_q;
      dl_q <= ch[DLEN-1:0];
      lvl_q <= lvl;
      sreq_q <= sreq_d;
      gs_q <= gs_d;
      blank_q <= blank_d;
      hold_q <= hold_d;
      cnt_q <= cnt_d;
      grp_q <= grp_d;
      trg_q <= trg_d;
      trgc_q <= trgc_d;
      trge_q <= trge_d;
    end
  end
`ifdef TRIG_TIMESTAMP_EN
  logic [CNT_W-1:0] ts_cnt_q, evt_q;
  logic [CNT_W-1:0] ts_q [NBANK];
  logic acc;
  assign acc = trig && !INST_START && !INST_STOP && !INST_READOUT;
  always_ff @(posedge FCLK) begin
    if (RST) begin
      ts_cnt_q <= '0;
      evt_q <= '0;
      for (int i = 0; i < NBANK; i++) ts_q[i] <= '0;
    end else begin
      ts_cnt_q <= INST_START ? '0 : ts_cnt_q + CNT_W'(1);
      if (acc) ts_q[cnt_q] <= ts_cnt_q;
      evt_q <= EVT_SEL < TC_W'(NBANK) ? ts_q[EVT_SEL] : '0;
    end
  end
  assign EVT_TS = evt_q;
`else
  assign EVT_TS = '0;
`endif
  assign TRIGGER = trg_q;
  assign TRIGGERC = trgc_q;
  assign TRIGGERE = trge_q;
  assign STOP_REQUEST = sreq_q;
  assign TRIG_CNT = cnt_q;
  assign CUR_GRP = grp_q;
endmodule

// File: tb/tb_ch_digital_ctrl_gen.sv
// tb_ch_digital_ctrl_gen: directed checks of the bank sequencer with NBANK=4, ARM_CYCLES=32
module tb_ch_digital_ctrl_gen;
  logic clk = 0, rst, start, stop, rdo, disc, pol;
  logic [2:0] mode, evt_sel, tcnt, cgrp;
  logic [4:0] tdel;
  logic [3:0] hold, trg, trgc;
  logic trge, sreq;
  logic [9:0] evt_ts;
  int nvec = 0, nerr = 0;
  logic [3:0] trg_e [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1111};
  logic [3:0] trgc_e [4] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
  always #5 clk = ~clk;
  ch_digital_ctrl_gen dut (
    .FCLK(clk), .RST(rst), .INST_START(start), .INST_STOP(stop), .INST_READOUT(rdo),
    .DISCRIMINATOR_OUTPUT(disc), .DISCRIMINATOR_POLARITY(pol), .MODE(mode),
    .TRIG_DELAY(tdel), .HOLDOFF(hold), .EVT_SEL(evt_sel), .TRIGGER(trg), .TRIGGERC(trgc),
    .TRIGGERE(trge), .STOP_REQUEST(sreq), .TRIG_CNT(tcnt), .CUR_GRP(cgrp), .EVT_TS(evt_ts)
  );
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic pulse();
    disc = 1;
    tick();
    disc = 0;
  endtask
  task automatic go(input logic [2:0] m);
    mode = m;
    start = 1;
    tick();
    start = 0;
  endtask
  initial begin
    {rst, start, stop, rdo, disc, pol} = '0;
    mode = 0; tdel = 0; hold = 0; evt_sel = 0;
    rst = 1;
    tick(2);
    rst = 0;
    chk("rst_trg", trg, 4'hf);
    chk("rst_trgc", trgc, 4'hf);
    chk("rst_trge", trge, 1);
    chk("rst_sreq", sreq, 0);
    chk("rst_cnt", tcnt, 0);
    chk("rst_grp", cgrp, 0);
    chk("rst_evt", evt_ts, 0);
    go(0);
    chk("st_trg", trg, 4'b1110);
    chk("st_trgc", trgc, 4'b0000);
    chk("st_trge", trge, 0);
    tick(40);
    for (int i = 0; i < 4; i++) begin
      pulse();
      tick();
      chk("lat_k1_grp", cgrp, i);
      tick();
      chk("step_grp", cgrp, i < 3 ? i + 1 : 3);
      chk("step_trg", trg, trg_e[i]);
      chk("step_trgc", trgc, trgc_e[i]);
      tick(38);
    end
    chk("tail_cnt", tcnt, 4);
    chk("tail_trge", trge, 0);
    chk("tail_sreq", sreq, 1);
    pulse();
    tick(3);
    chk("tail_ignore", tcnt, 4);
    go(1);
    tick(9);
    pulse();
    tick(20);
    chk("blank_cnt", tcnt, 0);
    tick(19);
    pulse();
    tick(2);
    chk("m1_cnt", tcnt, 1);
    chk("m1_trg", trg, 4'b0011);
    chk("m1_trgc", trgc, 4'b0011);
    hold = 8; tdel = 5;
    go(0);
    tick(40);
    pulse();
    tick(3);
    pulse();
    tick(2);
    chk("dly_k6", tcnt, 0);
    tick();
    chk("dly_k7", tcnt, 1);
    tick(20);
    chk("hold_cnt", tcnt, 1);
    chk("hold_grp", cgrp, 1);
    hold = 0; tdel = 0;
    go(2);
    tick(40);
    pulse();
    tick(2);
    chk("m2_cnt", tcnt, 1);
    chk("m2_trg", trg, 4'hf);
    chk("m2_trge", trge, 0);
    stop = 1;
    tick();
    stop = 0;
    chk("stop_trg", trg, 4'hf);
    chk("stop_trgc", trgc, 4'hf);
    chk("stop_trge", trge, 1);
    chk("stop_sreq", sreq, 1);
    chk("stop_cnt", tcnt, 1);
    go(2);
    chk("restart_sreq", sreq, 0);
    chk("restart_cnt", tcnt, 0);
    tick(40);
    pulse();
    tick();
    stop = 1;
    tick();
    stop = 0;
    chk("drop_cnt", tcnt, 0);
    chk("drop_trge", trge, 1);
    disc = 1;
    go(0);
    tick(45);
    chk("lvl_high_cnt", tcnt, 0);
    disc = 0;
    tick(3);
    pulse();
    tick(2);
    chk("after_lvl_cnt", tcnt, 1);
    rdo = 1;
    tick();
    rdo = 0;
    chk("rdo_trg", trg, 4'hf);
    chk("rdo_trge", trge, 1);
    start = 1; stop = 1; mode = 0;
    tick();
    {start, stop} = '0;
    chk("prio_trge", trge, 0);
    chk("prio_trg", trg, 4'b1110);
    pol = 1;
    tick(40);
    disc = 1;
    tick(4);
    chk("pol_cnt", tcnt, 0);
    disc = 0;
    tick(3);
    chk("pol_fall_cnt", tcnt, 1);
    disc = 1; pol = 0;
    tick(5);
    disc = 0;
`ifdef TRIG_TIMESTAMP_EN
    go(0);
    tick(98);
    pulse();
    tick(2);
    chk("ts_cnt1", tcnt, 1);
    tick(197);
    pulse();
    tick(2);
    chk("ts_cnt2", tcnt, 2);
    evt_sel = 1;
    tick();
    chk("ts_slot1", evt_ts, 300);
    evt_sel = 0;
    tick();
    chk("ts_slot0", evt_ts, 100);
    evt_sel = 4;
    tick();
    chk("ts_oob", evt_ts, 0);
`else
    evt_sel = 1;
    tick(2);
    chk("ts_off", evt_ts, 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/ch_digital_ctrl_gen.md
Name: ch_digital_ctrl_gen

Overview:
- Parametrised, fully synchronous successor of the per-channel sampling controller.
- Steers NBANK fast SCA banks plus one slow bank (E) through a trigger-driven ping-pong sequence, in groups of 1, 2, 4… banks chosen by MODE.
- Adds programmable trigger delay, post-start blanking, trigger holdoff and per-trigger timestamps.
- Sits between the channel discriminator/analog SCA latches and the chip-level SPI/readout logic.

Parameters:
- NBANK, 4: number of fast banks; power of two, ≥1.
- DELAY_W, 5: width of TRIG_DELAY; delay line depth is 2^DELAY_W-1.
- ARM_CYCLES, 32: blanking length in FCLK cycles after a start.
- HOLD_W, 4: width of HOLDOFF.
- CNT_W, 10: timestamp counter width.
- Derived: MODE_W = $clog2(NBANK)+1; TC_W = $clog2(NBANK+1).

Ports:
- FCLK  in  1  sampling-domain clock.
- RST  in  1  synchronous, active-high reset.
- INST_START  in  1  synchronous start pulse; latches MODE.
- INST_STOP  in  1  synchronous stop pulse.
- INST_READOUT  in  1  synchronous readout-entry pulse.
- DISCRIMINATOR_OUTPUT  in  1  asynchronous discriminator level.
- DISCRIMINATOR_POLARITY  in  1  1 inverts the discriminator.
- MODE  in  MODE_W  group size G = 1<<MODE, clamped to NBANK.
- TRIG_DELAY  in  DELAY_W  extra trigger delay in cycles.
- HOLDOFF  in  HOLD_W  dead cycles after an accepted trigger.
- EVT_SEL  in  TC_W  timestamp slot select.
- TRIGGER  out  NBANK  per-bank write enable, 0 = sampling.
- TRIGGERC  out  NBANK  per-bank complete/hold, 1 = done.
- TRIGGERE  out  1  slow-bank enable, 0 = sampling.
- STOP_REQUEST  out  1  sticky: first trigger seen.
- TRIG_CNT  out  TC_W  accepted triggers since start.
- CUR_GRP  out  TC_W  active group index.
- EVT_TS  out  CNT_W  timestamp of slot EVT_SEL.

Behaviour:
- Reset (RST high at an FCLK edge):
  - State INIT.
  - TRIGGER, TRIGGERC and TRIGGERE all 1.
  - STOP_REQUEST, TRIG_CNT, CUR_GRP and EVT_TS all 0.
  - Timestamp array, delay line and synchroniser cleared.
- Priority per edge: RST > INST_START > INST_STOP > INST_READOUT > trigger.
- States: INIT, SAMPLING, TAIL, STOPPED, READOUT.
  - INST_START from any state → SAMPLING. Latch G; NGRP = NBANK/G; CUR_GRP=0; TRIG_CNT=0; STOP_REQUEST=0; start blanking counter=ARM_CYCLES; timestamp counter=0.
  - INST_STOP → STOPPED.
  - INST_READOUT → READOUT.
  - STOPPED and READOUT exit only on INST_START or RST.
- Trigger path:
  - Two-flop synchroniser, then delay line.
  - Tap is synchroniser output when TRIG_DELAY=0, else delay stage TRIG_DELAY.
  - lvl = tap ^ DISCRIMINATOR_POLARITY.
  - Trigger = rising edge of lvl, only when all hold: state SAMPLING, blanking count 0, holdoff count 0.
  - A level already high when blanking ends is not a trigger.
- Latency: DISCRIMINATOR_OUTPUT sampled high at edge k → state and outputs change at edge k+2+TRIG_DELAY.
- Accepted trigger:
  - TRIG_CNT+1, STOP_REQUEST←1, holdoff count←HOLDOFF.
  - If CUR_GRP=NGRP-1 → TAIL, else CUR_GRP+1.
- Outputs are registered and computed from next state.
- SAMPLING, bank b with group g=b/G:
  - g<CUR_GRP: TRIGGER=1, TRIGGERC=1.
  - g=CUR_GRP: TRIGGER=0, TRIGGERC=0.
  - g>CUR_GRP: TRIGGER=1, TRIGGERC=0.
  - TRIGGERE=0.
- TAIL: all TRIGGER/TRIGGERC=1, TRIGGERE=0; triggers ignored; TRIG_CNT stays at NGRP.
- INIT/STOPPED/READOUT: all outputs 1 (TRIGGER, TRIGGERC, TRIGGERE); TRIG_CNT and CUR_GRP hold.
- Blanking and holdoff counters decrement to 0 and saturate there; blanking count is independent of holdoff.
- A trigger coincident with INST_STOP is dropped.

Optional Feature:
- Macro TRIG_TIMESTAMP_EN.
- Defined:
  - Free-running CNT_W counter, wraps modulo 2^CNT_W, zeroed by INST_START.
  - Each accepted trigger stores the counter into slot TRIG_CNT (pre-increment).
  - EVT_TS = slot EVT_SEL, registered, 1-cycle latency; EVT_SEL ≥ NBANK returns 0.
- Undefined: no counter or array; EVT_TS tied 0.

Test Plan:
- RST, then INST_START MODE=0 → TRIGGER=4'b1110, TRIGGERC=0, TRIGGERE=0.
- MODE=0, TRIG_DELAY=0, four discriminator pulses spaced 40 cycles, HOLDOFF=0:
  - CUR_GRP steps 0→1→2→3.
  - TRIG_CNT=4; state TAIL; TRIGGER=4'b1111, TRIGGERE=0.
  - Each step lands 2 edges after the pulse.
- MODE=1, pulse at cycle 10 (inside ARM_CYCLES=32) → ignored, TRIG_CNT=0; pulse at cycle 50 → TRIGGER=4'b0011, TRIGGERC=4'b0011.
- HOLDOFF=8, TRIG_DELAY=5, pulses 4 cycles apart → only first accepted, TRIG_CNT=1; response 7 edges after pulse.
- MODE=2, pulse accepted, then INST_STOP → STOPPED, all outputs 1, STOP_REQUEST=1. Then INST_START → STOP_REQUEST=0, TRIG_CNT=0.
- TRIG_TIMESTAMP_EN, triggers at counter values 100 and 300, EVT_SEL=1 → EVT_TS=300 one cycle later.
